// File: rtl/sar_search_controller.sv
// sar_search_controller
// Successive-approximation search FSM. It drives the B operand of a magnitude
// comparator and uses the L/G/E answers to narrow a [lo, hi] window until it
// finds the unknown A, or until the answers become inconsistent. It takes one
// comparator sample per clock. The result, probe count and status stay held
// for the display.

module sar_search_controller #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             cmp_l,
   input  logic             cmp_g,
   input  logic             cmp_e,
   output logic [WIDTH-1:0] guess,
   output logic             busy,
   output logic             done,
   output logic             found,
   output logic             error,
   output logic [WIDTH-1:0] result,
   output logic [WIDTH-1:0] probes
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      PROBE = 2'd1,
      DONE  = 2'd2
   } state_t;

   // lo/hi carry one extra bit so that lo can step past the top of the range
   localparam logic [WIDTH:0] HI_MAX = (WIDTH+1)'((1 << WIDTH) - 1);
   localparam logic [WIDTH:0] ONE_X  = (WIDTH+1)'(1);
   localparam logic [WIDTH:0] ZERO_X = '0;

   state_t           state_q;
   logic [WIDTH:0]   lo_q;
   logic [WIDTH:0]   hi_q;
   logic [WIDTH-1:0] guess_q;
   logic [WIDTH-1:0] result_q;
   logic [WIDTH-1:0] probes_q;
   logic             busy_q;
   logic             done_q;
   logic             found_q;
   logic             error_q;

   logic [WIDTH:0]   guess_ext;
   logic [WIDTH:0]   lo_d;
   logic [WIDTH:0]   hi_d;
   logic             lo_overrun;
   logic             hi_underrun;
   logic [2:0]       cmp_code;

   // Candidate window bounds for the two narrowing answers, plus their sanity checks
   always_comb begin
      guess_ext   = {1'b0, guess_q};
      lo_d        = guess_ext + ONE_X;
      hi_d        = guess_ext - ONE_X;
      lo_overrun  = (lo_d > hi_q);
      hi_underrun = (guess_q == '0) || (hi_d < lo_q);
      cmp_code    = {cmp_l, cmp_g, cmp_e};
   end

   // Search FSM: a start restarts the window, and each PROBE cycle consumes one comparator answer
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         lo_q     <= ZERO_X;
         hi_q     <= HI_MAX;
         guess_q  <= '0;
         result_q <= '0;
         probes_q <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         found_q  <= 1'b0;
         error_q  <= 1'b0;
      end else begin
         case (state_q)
            IDLE, DONE: begin
               if (start) begin
                  state_q  <= PROBE;
                  lo_q     <= ZERO_X;
                  hi_q     <= HI_MAX;
                  guess_q  <= WIDTH'((ZERO_X + HI_MAX) >> 1);
                  probes_q <= '0;
                  busy_q   <= 1'b1;
                  done_q   <= 1'b0;
                  found_q  <= 1'b0;
                  error_q  <= 1'b0;
               end
            end
            PROBE: begin
               probes_q <= probes_q + WIDTH'(1);
               case (cmp_code)
                  3'b001: begin
                     state_q  <= DONE;
                     busy_q   <= 1'b0;
                     done_q   <= 1'b1;
                     found_q  <= 1'b1;
                     result_q <= guess_q;
                  end
                  3'b010: begin
                     lo_q <= lo_d;
                     if (lo_overrun) begin
                        state_q <= DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        error_q <= 1'b1;
                     end else begin
                        guess_q <= WIDTH'((lo_d + hi_q) >> 1);
                     end
                  end
                  3'b100: begin
                     if (hi_underrun) begin
                        state_q <= DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        error_q <= 1'b1;
                     end else begin
                        hi_q    <= hi_d;
                        guess_q <= WIDTH'((lo_q + hi_d) >> 1);
                     end
                  end
                  default: begin
                     state_q <= DONE;
                     busy_q  <= 1'b0;
                     done_q  <= 1'b1;
                     error_q <= 1'b1;
                  end
               endcase
            end
            default: begin
               state_q <= IDLE;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign guess  = guess_q;
   assign busy   = busy_q;
   assign done   = done_q;
   assign found  = found_q;
   assign error  = error_q;
   assign result = result_q;
   assign probes = probes_q;

endmodule
